// File: rtl/enigma_pkg.sv
// Shared defaults, helper function and request record for the Enigma arbitration buffer.
package enigma_pkg;

   localparam int unsigned NUM_PORTS_DEF = 2;
   localparam int unsigned DEPTH_DEF     = 4;
   localparam int unsigned DATA_W_DEF    = 128;
   localparam int unsigned ID_W_DEF      = 5;
   localparam int unsigned QOS_W_DEF     = 2;

   // Source-port field width; never collapses to zero bits.
   function automatic int unsigned port_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef struct packed {
      logic [DATA_W_DEF-1:0] payload;
      logic [ID_W_DEF-1:0]   id;
      logic [QOS_W_DEF-1:0]  qos;
   } enigma_req_t;

endpackage

// File: rtl/enigma_port_fifo.sv
// Per-port request FIFO: ring buffer with wrap-bit pointers and a registered ready.
module enigma_port_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         empty,
   output logic         ready
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [AW:0]   count;
   logic [AW:0]   count_nxt;

   assign count = wr_ptr - rd_ptr;
   assign empty = (count == '0);
   assign rdata = mem[rd_ptr[AW-1:0]];

   always_comb begin
      count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ready  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         ready <= (count_nxt < (AW+1)'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/enigma_arb_buffer.sv
// N-port request buffer: per-port FIFOs, conflict park/retry slots, QoS-first
// round-robin arbiter and a single registered output port C.
module enigma_arb_buffer
   import enigma_pkg::*;
#(
   parameter int unsigned NUM_PORTS = NUM_PORTS_DEF,
   parameter int unsigned DEPTH     = DEPTH_DEF,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned ID_W      = ID_W_DEF,
   parameter int unsigned QOS_W     = QOS_W_DEF
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [NUM_PORTS-1:0]                  valid_i,
   output logic [NUM_PORTS-1:0]                  ready_i,
   input  logic [NUM_PORTS*DATA_W-1:0]           payload_i,
   input  logic [NUM_PORTS*ID_W-1:0]             id_i,
   input  logic [NUM_PORTS*QOS_W-1:0]            qos_i,
   output logic                                  valid_c,
   input  logic                                  ready_c,
   output logic [DATA_W-1:0]                     payload_c,
   output logic [port_w(NUM_PORTS)+ID_W-1:0]     id_c,
   output logic [QOS_W-1:0]                      qos_c,
   input  logic                                  conflict_c,
   input  logic                                  release_c,
   input  logic [port_w(NUM_PORTS)+ID_W-1:0]     releaseid_c
);

   localparam int unsigned PW = port_w(NUM_PORTS);
   localparam int unsigned RW = DATA_W + ID_W + QOS_W;

   // Request record layout inside FIFOs and park slots: {payload, id, qos}
   logic [RW-1:0]          fifo_wdata [NUM_PORTS];
   logic [RW-1:0]          fifo_head  [NUM_PORTS];
   logic [NUM_PORTS-1:0]   fifo_empty;
   logic [NUM_PORTS-1:0]   fifo_ready;
   logic [NUM_PORTS-1:0]   push;
   logic [NUM_PORTS-1:0]   pop;

   logic [RW-1:0]          park_q [NUM_PORTS];
   logic [NUM_PORTS-1:0]   park_vld;
   logic [NUM_PORTS-1:0]   park_clr;
   logic [NUM_PORTS-1:0]   blocked;

   logic [NUM_PORTS-1:0]   cand;
   logic [RW-1:0]          cand_data [NUM_PORTS];

   logic [PW-1:0]          rr_ptr;
   logic [PW-1:0]          rr_nxt;
   logic [PW-1:0]          src;
   logic [PW-1:0]          win;
   logic                   win_vld;
   logic [QOS_W-1:0]       win_qos;
   logic [RW-1:0]          win_data;
   logic                   accept;
   logic                   reject;
   logic                   load;

   assign ready_i = fifo_ready;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      assign fifo_wdata[p] = {payload_i[p*DATA_W +: DATA_W], id_i[p*ID_W +: ID_W], qos_i[p*QOS_W +: QOS_W]};
      assign push[p]       = valid_i[p] & fifo_ready[p];

      enigma_port_fifo #(
         .DEPTH (DEPTH),
         .W     (RW)
      ) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .push  (push[p]),
         .pop   (pop[p]),
         .wdata (fifo_wdata[p]),
         .rdata (fifo_head[p]),
         .empty (fifo_empty[p]),
         .ready (fifo_ready[p])
      );
   end

   always_comb begin
      accept = valid_c & ready_c & ~conflict_c;
      reject = valid_c & conflict_c;
      load   = ~valid_c | accept | reject;
      src    = id_c[ID_W +: PW];

      // A parked entry shadows the FIFO head so per-port order is kept; the
      // port being rejected this edge cannot refill the output in the same edge.
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         cand[p]      = park_vld[p] ? ~blocked[p] : ~fifo_empty[p];
         cand_data[p] = park_vld[p] ? park_q[p] : fifo_head[p];
         if (reject && (src == PW'(p))) cand[p] = 1'b0;
      end

      win_vld = 1'b0;
      win     = '0;
      win_qos = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         int unsigned idx;
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         if (cand[idx] && (!win_vld || (cand_data[idx][QOS_W-1:0] > win_qos))) begin
            win_vld = 1'b1;
            win     = PW'(idx);
            win_qos = cand_data[idx][QOS_W-1:0];
         end
      end
      win_data = cand_data[win];
      rr_nxt   = (int'(win) == NUM_PORTS - 1) ? '0 : win + 1'b1;

      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         pop[p]      = load & win_vld & (win == PW'(p)) & ~park_vld[p];
         park_clr[p] = load & win_vld & (win == PW'(p)) &  park_vld[p];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         park_vld <= '0;
         blocked  <= '0;
         for (int unsigned p = 0; p < NUM_PORTS; p++) park_q[p] <= '0;
      end else begin
         for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (park_clr[p]) park_vld[p] <= 1'b0;
            if (reject && (src == PW'(p))) begin
               park_vld[p] <= 1'b1;
               blocked[p]  <= 1'b1;
               park_q[p]   <= {payload_c, id_c[ID_W-1:0], qos_c};
            end else if (release_c && park_vld[p] && blocked[p] &&
                         (releaseid_c == {PW'(p), park_q[p][QOS_W +: ID_W]})) begin
               blocked[p] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_c   <= 1'b0;
         payload_c <= '0;
         id_c      <= '0;
         qos_c     <= '0;
         rr_ptr    <= '0;
      end else if (load) begin
         if (win_vld) begin
            valid_c   <= 1'b1;
            payload_c <= win_data[QOS_W+ID_W +: DATA_W];
            id_c      <= {win, win_data[QOS_W +: ID_W]};
            qos_c     <= win_data[QOS_W-1:0];
            rr_ptr    <= rr_nxt;
         end else begin
            valid_c   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_enigma_arb_buffer.sv
// Self-checking bench for enigma_arb_buffer: directed scenarios plus random traffic
// against a queue-based transaction model of the buffer.
module tb_enigma_arb_buffer;
   import enigma_pkg::*;

   localparam int NP    = 2;
   localparam int DEPTH = 4;
   localparam int DW    = 128;
   localparam int IW    = 5;
   localparam int QW    = 2;
   localparam int PW    = 1;
   localparam int CW    = 128;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NP-1:0]        valid_i;
   logic [NP-1:0]        ready_i;
   logic [NP*DW-1:0]     payload_i;
   logic [NP*IW-1:0]     id_i;
   logic [NP*QW-1:0]     qos_i;
   logic                 valid_c;
   logic                 ready_c;
   logic [DW-1:0]        payload_c;
   logic [PW+IW-1:0]     id_c;
   logic [QW-1:0]        qos_c;
   logic                 conflict_c;
   logic                 release_c;
   logic [PW+IW-1:0]     releaseid_c;

   always #5 clk = ~clk;

   enigma_arb_buffer #(
      .NUM_PORTS (NP),
      .DEPTH     (DEPTH),
      .DATA_W    (DW),
      .ID_W      (IW),
      .QOS_W     (QW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid_i     (valid_i),
      .ready_i     (ready_i),
      .payload_i   (payload_i),
      .id_i        (id_i),
      .qos_i       (qos_i),
      .valid_c     (valid_c),
      .ready_c     (ready_c),
      .payload_c   (payload_c),
      .id_c        (id_c),
      .qos_c       (qos_c),
      .conflict_c  (conflict_c),
      .release_c   (release_c),
      .releaseid_c (releaseid_c)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Model: per-port queue of outstanding requests in arrival order. The front
   // entry is the one in the output register, in the park slot, or the FIFO head.
   enigma_req_t expq [NP][$];
   bit          parked_m  [NP];
   bit          blocked_m [NP];
   bit          ov_m;
   int          os_m;
   int          rr_m;
   int          dut_ids [$];

   function automatic logic [PW+IW-1:0] tag_id(input int p, input logic [IW-1:0] id);
      return {PW'(p), id};
   endfunction

   task automatic model_reset();
      for (int p = 0; p < NP; p++) begin
         expq[p].delete();
         parked_m[p]  = 0;
         blocked_m[p] = 0;
      end
      ov_m = 0;
      os_m = 0;
      rr_m = 0;
   endtask

   task automatic idle_inputs();
      valid_i     = '0;
      payload_i   = '0;
      id_i        = '0;
      qos_i       = '0;
      ready_c     = 1'b0;
      conflict_c  = 1'b0;
      release_c   = 1'b0;
      releaseid_c = '0;
   endtask

   task automatic set_port(input int p, input bit v, input logic [IW-1:0] id,
                           input logic [QW-1:0] q, input logic [DW-1:0] pl);
      valid_i[p]            = v;
      id_i[p*IW +: IW]      = id;
      qos_i[p*QW +: QW]     = q;
      payload_i[p*DW +: DW] = pl;
   endtask

   // One clock edge: advance the model from pre-edge inputs, then compare.
   task automatic cycle();
      bit acc, conf, load;
      bit cand [NP];
      enigma_req_t ce [NP];
      enigma_req_t e;
      int w;
      logic [QW-1:0] bq;

      acc  = ov_m && ready_c && !conflict_c;
      conf = ov_m && conflict_c;
      load = !ov_m || acc || conf;
      if (valid_c && ready_c && !conflict_c) dut_ids.push_back(int'(id_c));

      for (int p = 0; p < NP; p++) begin
         cand[p] = 0;
         ce[p]   = '0;
         if (ov_m && p == os_m) begin
            if (acc && expq[p].size() >= 2) begin
               cand[p] = 1;
               ce[p]   = expq[p][1];
            end
         end else if (expq[p].size() > 0 && !blocked_m[p]) begin
            cand[p] = 1;
            ce[p]   = expq[p][0];
         end
      end

      if (release_c)
         for (int p = 0; p < NP; p++)
            if (blocked_m[p] && tag_id(p, expq[p][0].id) == releaseid_c) blocked_m[p] = 0;
      if (acc) void'(expq[os_m].pop_front());
      if (conf) begin
         parked_m[os_m]  = 1;
         blocked_m[os_m] = 1;
      end
      if (load) begin
         w  = -1;
         bq = '0;
         for (int i = 0; i < NP; i++) begin
            int p;
            p = (rr_m + i) % NP;
            if (cand[p] && (w < 0 || ce[p].qos > bq)) begin
               w  = p;
               bq = ce[p].qos;
            end
         end
         if (w >= 0) begin
            ov_m        = 1;
            os_m        = w;
            parked_m[w] = 0;
            rr_m        = (w + 1) % NP;
         end else begin
            ov_m = 0;
         end
      end

      for (int p = 0; p < NP; p++) begin
         if (valid_i[p] && ready_i[p]) begin
            e.payload = payload_i[p*DW +: DW];
            e.id      = id_i[p*IW +: IW];
            e.qos     = qos_i[p*QW +: QW];
            expq[p].push_back(e);
         end
      end

      @(posedge clk);
      #1;

      check("valid_c", CW'(valid_c), CW'(ov_m));
      if (ov_m) begin
         e = expq[os_m][0];
         check("id_c", CW'(id_c), CW'(tag_id(os_m, e.id)));
         check("qos_c", CW'(qos_c), CW'(e.qos));
         check("payload_c", payload_c, e.payload);
      end
      for (int p = 0; p < NP; p++) begin
         int cnt;
         cnt = expq[p].size() - ((ov_m && os_m == p) ? 1 : 0) - (parked_m[p] ? 1 : 0);
         check("ready_i", CW'(ready_i[p]), CW'(cnt < DEPTH));
      end
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid_c", CW'(valid_c), '0);
      check("rst_ready_i", CW'(ready_i), '0);
      check("rst_id_c", CW'(id_c), '0);
      check("rst_qos_c", CW'(qos_c), '0);
      check("rst_payload_c", payload_c, '0);
      rst_n = 1'b1;
      cycle();
      check("rst_ready_up", CW'(ready_i), CW'({NP{1'b1}}));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pushes;
      int exp_ids [5];

      // Single request: one-cycle latency, then accept.
      do_reset();
      set_port(0, 1, 5'd3, 2'd1, {16{8'hA5}});
      cycle();
      valid_i = '0;
      check("t1_no_bypass", CW'(valid_c), '0);
      cycle();
      check("t1_id", CW'(id_c), CW'(6'd3));
      ready_c = 1'b1;
      cycle();
      check("t1_accepted", CW'(valid_c), '0);

      // Backpressure: DEPTH in FIFO + 1 in the output register.
      do_reset();
      pushes = 0;
      for (int k = 0; k < 10 && ready_i[1]; k++) begin
         set_port(1, 1, IW'(k), 2'd0, DW'(k + 100));
         pushes++;
         cycle();
      end
      valid_i = '0;
      check("t2_pushes", CW'(pushes), CW'(DEPTH + 1));
      ready_c = 1'b1;
      repeat (8) cycle();
      check("t2_drained", CW'(expq[1].size()), '0);

      // Equal qos: round-robin alternation.
      do_reset();
      ready_c = 1'b1;
      dut_ids.delete();
      for (int k = 0; k < 10; k++) begin
         set_port(0, 1, IW'(k), 2'd2, DW'(k));
         set_port(1, 1, IW'(k + 16), 2'd2, DW'(k + 50));
         cycle();
      end
      valid_i = '0;
      repeat (12) cycle();
      check("t3_count", CW'(dut_ids.size() >= 6), CW'(1));
      for (int i = 0; i < 6 && i < dut_ids.size(); i++)
         check("t3_alt", CW'(dut_ids[i] >> IW), CW'(i % 2));

      // Higher qos on port 1 drains it first.
      do_reset();
      dut_ids.delete();
      for (int k = 0; k < 3; k++) begin
         set_port(0, 1, IW'(k), 2'd1, DW'(k));
         set_port(1, 1, IW'(k + 8), 2'd3, DW'(k + 8));
         cycle();
      end
      valid_i = '0;
      ready_c = 1'b1;
      repeat (10) cycle();
      check("t3q_count", CW'(dut_ids.size()), CW'(6));
      for (int i = 0; i < 6 && i < dut_ids.size(); i++)
         check("t3q_src", CW'(dut_ids[i] >> IW), CW'(i < 3 ? 1 : 0));

      // Conflict parks port 0, release re-presents it ahead of later beats.
      do_reset();
      set_port(0, 1, 5'd3, 2'd1, {16{8'hA5}});
      cycle();
      set_port(0, 1, 5'd4, 2'd1, DW'(4));
      set_port(1, 1, 5'd7, 2'd1, DW'(7));
      cycle();
      set_port(0, 1, 5'd5, 2'd1, DW'(5));
      set_port(1, 1, 5'd8, 2'd1, DW'(8));
      cycle();
      valid_i = '0;
      check("t4_present", CW'(id_c), CW'(6'd3));
      conflict_c = 1'b1;
      cycle();
      conflict_c = 1'b0;
      check("t4_other", CW'(id_c), CW'(6'd39));
      dut_ids.delete();
      ready_c = 1'b1;
      repeat (3) cycle();
      check("t4_blocked_idle", CW'(valid_c), '0);
      release_c   = 1'b1;
      releaseid_c = 6'd3;
      cycle();
      release_c = 1'b0;
      repeat (4) cycle();
      exp_ids = '{39, 40, 3, 4, 5};
      check("t4_count", CW'(dut_ids.size()), CW'(5));
      for (int i = 0; i < 5 && i < dut_ids.size(); i++)
         check("t4_order", CW'(dut_ids[i]), CW'(exp_ids[i]));

      // Release in the same cycle as the conflict is dropped.
      do_reset();
      set_port(0, 1, 5'd3, 2'd1, DW'(33));
      cycle();
      valid_i = '0;
      cycle();
      conflict_c  = 1'b1;
      release_c   = 1'b1;
      releaseid_c = 6'd3;
      cycle();
      conflict_c = 1'b0;
      release_c  = 1'b0;
      ready_c    = 1'b1;
      repeat (3) cycle();
      check("t5_still_blocked", CW'(valid_c), '0);
      release_c = 1'b1;
      cycle();
      release_c = 1'b0;
      cycle();
      check("t5_reissued", CW'(id_c), CW'(6'd3));
      cycle();

      // Asynchronous reset with full FIFOs and a presented request.
      do_reset();
      for (int k = 0; k < 10; k++) begin
         set_port(0, 1, IW'(k), 2'($urandom), {$urandom, $urandom, $urandom, $urandom});
         set_port(1, 1, IW'(k), 2'($urandom), {$urandom, $urandom, $urandom, $urandom});
         cycle();
      end
      valid_i = '0;
      check("t6_pre_valid", CW'(valid_c), CW'(1));
      check("t6_pre_full", CW'(ready_i), '0);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_valid_c", CW'(valid_c), '0);
      check("t6_ready_i", CW'(ready_i), '0);
      check("t6_payload_c", payload_c, '0);
      check("t6_id_c", CW'(id_c), '0);
      check("t6_qos_c", CW'(qos_c), '0);
      do_reset();
      set_port(1, 1, 5'd9, 2'd0, DW'(99));
      cycle();
      valid_i = '0;
      cycle();
      check("t6_fresh", CW'(id_c), CW'(6'd41));

      // Random traffic with conflicts and releases.
      do_reset();
      for (int n = 0; n < 2000; n++) begin
         int x;
         for (int p = 0; p < NP; p++)
            set_port(p, bit'($urandom_range(0, 1)), IW'($urandom), QW'($urandom),
                     {$urandom, $urandom, $urandom, $urandom});
         ready_c    = ($urandom_range(0, 9) < 7);
         conflict_c = ov_m && ($urandom_range(0, 9) == 0);
         release_c  = ($urandom_range(0, 3) == 0);
         x = $urandom_range(0, NP - 1);
         if (blocked_m[x] && $urandom_range(0, 1) == 1) releaseid_c = tag_id(x, expq[x][0].id);
         else releaseid_c = (PW+IW)'($urandom);
         cycle();
      end

      // Drain everything, releasing any parked entries.
      idle_inputs();
      ready_c = 1'b1;
      for (int n = 0; n < 400; n++) begin
         int left;
         release_c = 1'b0;
         for (int p = 0; p < NP; p++) begin
            if (blocked_m[p]) begin
               release_c   = 1'b1;
               releaseid_c = tag_id(p, expq[p][0].id);
               break;
            end
         end
         cycle();
         left = 0;
         for (int p = 0; p < NP; p++) left += expq[p].size();
         if (left == 0 && !ov_m) break;
      end
      begin
         int left;
         left = 0;
         for (int p = 0; p < NP; p++) left += expq[p].size();
         check("drain_left", CW'(left), '0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
